// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch/write-back inputs and D/E register outputs of the decode stage
// master: drives instr_d, stall_d, flush_d and the write-back port; observes the *_e outputs
// slave : the decode stage itself
interface decode_stage_if #(parameter int DATA_W = 32);
  logic [31:0] instr_d;
  logic stall_d, flush_d;
  logic regwrite_w;
  logic [4:0] rd_w;
  logic [DATA_W-1:0] result_w;
  logic [DATA_W-1:0] rd1_e, rd2_e, imm_e;
  logic [4:0] rd_e;
  logic [2:0] alu_ctrl_e;
  logic alusrc_e, regwrite_e, memwrite_e, resultsrc_e, valid_e, illegal_e;
  modport master (
    output instr_d, stall_d, flush_d, regwrite_w, rd_w, result_w,
    input  rd1_e, rd2_e, imm_e, rd_e, alu_ctrl_e, alusrc_e, regwrite_e, memwrite_e, resultsrc_e, valid_e, illegal_e
  );
  modport slave (
    input  instr_d, stall_d, flush_d, regwrite_w, rd_w, result_w,
    output rd1_e, rd2_e, imm_e, rd_e, alu_ctrl_e, alusrc_e, regwrite_e, memwrite_e, resultsrc_e, valid_e, illegal_e
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I-subset decode, 32-entry register file and D/E pipeline register
// clk, rst (async, active-high); bus (decode_stage_if.slave): instr_d/stall_d/flush_d from fetch,
// regwrite_w/rd_w/result_w from write-back, registered rd1_e/rd2_e/imm_e/rd_e/controls to execute.
// Define DECODE_WB_BYPASS_EN to let a same-cycle write-back flow straight into the captured operands.
module decode_stage #(parameter int DATA_W = 32) (
  input logic clk,
  input logic rst,
  decode_stage_if.slave bus
);
  typedef struct packed {
    logic [DATA_W-1:0] rd1, rd2, imm;
    logic [4:0] rd;
    logic [2:0] alu;
    logic alusrc, regwrite, memwrite, resultsrc, valid, illegal;
  } de_t;
  logic [DATA_W-1:0] rf [32];
  logic [31:0] instr;
  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rs1, rs2;
  logic f3_ok, is_r, is_i, is_lw, is_sw, legal;
  logic [2:0] alu;
  logic [DATA_W-1:0] r1, r2;
  de_t d, q;
  assign instr = bus.instr_d;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f3_ok = f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010;
  assign is_r = op == 7'b0110011 && f3_ok;
  assign is_i = op == 7'b0010011 && f3_ok;
  assign is_lw = op == 7'b0000011 && f3 == 3'b010;
  assign is_sw = op == 7'b0100011 && f3 == 3'b010;
  assign legal = is_r | is_i | is_lw | is_sw;
  // instr[30] selects sub only for R-type; I-type funct3 000 is always addi
  assign alu = f3 == 3'b000 ? {2'b00, is_r & instr[30]} :
               f3 == 3'b111 ? 3'b010 :
               f3 == 3'b110 ? 3'b011 : 3'b101;
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (bus.regwrite_w && bus.rd_w != 5'd0) rf[bus.rd_w] <= bus.result_w;
  // rf[0] is never written, so x0 reads 0 without extra muxing
`ifdef DECODE_WB_BYPASS_EN
  assign r1 = bus.regwrite_w && bus.rd_w != 5'd0 && bus.rd_w == rs1 ? bus.result_w : rf[rs1];
  assign r2 = bus.regwrite_w && bus.rd_w != 5'd0 && bus.rd_w == rs2 ? bus.result_w : rf[rs2];
`else
  assign r1 = rf[rs1];
  assign r2 = rf[rs2];
`endif
  always_comb begin
    d = '0;
    d.rd1 = r1;
    d.rd2 = r2;
    d.imm = is_sw ? {{(DATA_W-12){instr[31]}}, instr[31:25], instr[11:7]} : {{(DATA_W-12){instr[31]}}, instr[31:20]};
    d.rd = instr[11:7];
    d.alu = is_r | is_i ? alu : 3'b000;
    d.alusrc = is_i | is_lw | is_sw;
    d.regwrite = is_r | is_i | is_lw;
    d.memwrite = is_sw;
    d.resultsrc = is_lw;
    d.valid = |instr;
    d.illegal = |instr & ~legal;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (bus.flush_d) q <= '0;
    else if (!bus.stall_d) q <= d;
  assign bus.rd1_e = q.rd1;
  assign bus.rd2_e = q.rd2;
  assign bus.imm_e = q.imm;
  assign bus.rd_e = q.rd;
  assign bus.alu_ctrl_e = q.alu;
  assign bus.alusrc_e = q.alusrc;
  assign bus.regwrite_e = q.regwrite;
  assign bus.memwrite_e = q.memwrite;
  assign bus.resultsrc_e = q.resultsrc;
  assign bus.valid_e = q.valid;
  assign bus.illegal_e = q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: random and directed checks of decode_stage against a spec-level model
module tb_decode_stage;
  logic clk = 0;
  logic rst = 1;
  int n_chk = 0, n_pass = 0;
  decode_stage_if #(.DATA_W(32)) bus ();
  decode_stage #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] rd1, rd2, imm;
    logic [4:0] rd;
    logic [2:0] alu;
    logic alusrc, regwrite, memwrite, resultsrc, valid, illegal, imm_chk;
  } exp_t;
  logic [31:0] mrf [32];
  exp_t exp_q;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask
  function automatic exp_t bubble();
    exp_t e;
    e = '{default: '0};
    e.imm_chk = 1;
    return e;
  endfunction
  function automatic logic [31:0] rd_op(input logic [4:0] r, input logic wbe, input logic [4:0] wrd, input logic [31:0] wres);
    if (r == 0) return 0;
`ifdef DECODE_WB_BYPASS_EN
    if (wbe && wrd == r) return wres;
`endif
    return mrf[r];
  endfunction
  function automatic exp_t model(input logic [31:0] ins, input logic wbe, input logic [4:0] wrd, input logic [31:0] wres);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    int simm;
    e = bubble();
    if (ins == 0) return e;
    op = ins[6:0];
    f3 = ins[14:12];
    e.valid = 1;
    e.imm_chk = 0;
    e.rd = ins[11:7];
    e.rd1 = rd_op(ins[19:15], wbe, wrd, wres);
    e.rd2 = rd_op(ins[24:20], wbe, wrd, wres);
    if (op == 7'h33 || op == 7'h13) begin
      case (f3)
        3'd0: e.alu = (op == 7'h33 && ins[30]) ? 3'd1 : 3'd0;
        3'd7: e.alu = 3'd2;
        3'd6: e.alu = 3'd3;
        3'd2: e.alu = 3'd5;
        default: e.illegal = 1;
      endcase
      if (e.illegal) e.alu = 0;
      else begin
        e.regwrite = 1;
        if (op == 7'h13) begin
          e.alusrc = 1;
          simm = $signed(ins[31:20]);
          e.imm = simm;
          e.imm_chk = 1;
        end
      end
    end else if (op == 7'h03 && f3 == 3'd2) begin
      e.regwrite = 1; e.alusrc = 1; e.resultsrc = 1;
      simm = $signed(ins[31:20]);
      e.imm = simm;
      e.imm_chk = 1;
    end else if (op == 7'h23 && f3 == 3'd2) begin
      e.memwrite = 1; e.alusrc = 1;
      simm = $signed({ins[31:25], ins[11:7]});
      e.imm = simm;
      e.imm_chk = 1;
    end else e.illegal = 1;
    return e;
  endfunction
  task automatic check_all(input string tag);
    chk({tag, ".rd1"}, bus.rd1_e, exp_q.rd1);
    chk({tag, ".rd2"}, bus.rd2_e, exp_q.rd2);
    if (exp_q.imm_chk) chk({tag, ".imm"}, bus.imm_e, exp_q.imm);
    chk({tag, ".rd"}, {27'd0, bus.rd_e}, {27'd0, exp_q.rd});
    chk({tag, ".alu"}, {29'd0, bus.alu_ctrl_e}, {29'd0, exp_q.alu});
    chk({tag, ".ctl"},
        {26'd0, bus.alusrc_e, bus.regwrite_e, bus.memwrite_e, bus.resultsrc_e, bus.valid_e, bus.illegal_e},
        {26'd0, exp_q.alusrc, exp_q.regwrite, exp_q.memwrite, exp_q.resultsrc, exp_q.valid, exp_q.illegal});
  endtask
  task automatic step(input string tag, input logic [31:0] ins, input logic st = 0, input logic fl = 0,
                      input logic wbe = 0, input logic [4:0] wrd = 0, input logic [31:0] wres = 0);
    bus.instr_d = ins; bus.stall_d = st; bus.flush_d = fl;
    bus.regwrite_w = wbe; bus.rd_w = wrd; bus.result_w = wres;
    if (fl) exp_q = bubble();
    else if (!st) exp_q = model(ins, wbe, wrd, wres);
    @(posedge clk); #1;
    if (wbe && wrd != 0) mrf[wrd] = wres;
    check_all(tag);
  endtask
  function automatic logic [31:0] rand_instr();
    logic [4:0] rs1, rs2, rd;
    logic [2:0] f3;
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 31));
    f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd2;
    case ($urandom_range(0, 6))
      0: return {($urandom_range(0, 1) ? 7'h20 : 7'h00), rs2, rs1, 3'($urandom), rd, 7'h33};
      1: return {12'($urandom), rs1, 3'($urandom), rd, 7'h13};
      2: return {12'($urandom), rs1, f3, rd, 7'h03};
      3: return {7'($urandom), rs2, rs1, f3, 5'($urandom), 7'h23};
      4: return 32'h0;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic [31:0] held;
    for (int i = 0; i < 32; i++) mrf[i] = 0;
    exp_q = bubble();
    bus.instr_d = 32'h402081B3; bus.stall_d = 0; bus.flush_d = 0;
    bus.regwrite_w = 0; bus.rd_w = 0; bus.result_w = 0;
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst = 0;
    step("wb_x1", 32'h0, 0, 0, 1, 5'd1, 32'hA);
    step("wb_x2", 32'h0, 0, 0, 1, 5'd2, 32'h3);
    step("sub", 32'h402081B3);
    chk("sub.rd1_k", bus.rd1_e, 32'hA);
    chk("sub.rd2_k", bus.rd2_e, 32'h3);
    chk("sub.alu_k", {29'd0, bus.alu_ctrl_e}, 32'd1);
    chk("sub.rd_k", {27'd0, bus.rd_e}, 32'd3);
    chk("sub.rw_valid_k", {30'd0, bus.regwrite_e, bus.valid_e}, 32'd3);
    step("lw", 32'hFFC0A103);
    chk("lw.imm_k", bus.imm_e, 32'hFFFFFFFC);
    chk("lw.src_k", {30'd0, bus.resultsrc_e, bus.alusrc_e}, 32'd3);
    step("sw", 32'hFE20AE23);
    chk("sw.imm_k", bus.imm_e, 32'hFFFFFFFC);
    chk("sw.mw_rw_k", {30'd0, bus.memwrite_e, bus.regwrite_e}, 32'd2);
    step("add", 32'h002081B3);
    held = bus.rd2_e;
    for (int i = 0; i < 3; i++) begin
      step("stall", $urandom, 1);
      chk("stall.rd2_k", bus.rd2_e, held);
    end
    step("stall_flush", 32'h402081B3, 1, 1);
    chk("stall_flush.valid_k", {31'd0, bus.valid_e}, 32'd0);
    step("illegal", 32'h0000007F);
    chk("illegal.k", {29'd0, bus.illegal_e, bus.regwrite_e, bus.memwrite_e}, 32'd4);
    step("zero", 32'h0);
    chk("zero.k", {30'd0, bus.valid_e, bus.illegal_e}, 32'd0);
    step("bypass", 32'h000081B3, 0, 0, 1, 5'd1, 32'h55);
`ifdef DECODE_WB_BYPASS_EN
    chk("bypass.rd1_k", bus.rd1_e, 32'h55);
`else
    chk("bypass.rd1_k", bus.rd1_e, 32'hA);
`endif
    step("x0_wr", 32'h000001B3, 0, 0, 1, 5'd0, 32'h77);
    chk("x0_wr.rd1_k", bus.rd1_e, 32'h0);
    step("wb_x5", 32'h0, 0, 0, 1, 5'd5, 32'h1234);
    step("rd_x5", 32'h000281B3);
    #2;
    bus.instr_d = 32'h402081B3;
    rst = 1;
    #1;
    for (int i = 0; i < 32; i++) mrf[i] = 0;
    exp_q = bubble();
    check_all("async_rst");
    @(negedge clk) rst = 0;
    step("rd_x5_after_rst", 32'h000281B3);
    chk("rd_x5_after_rst.k", bus.rd1_e, 32'h0);
    for (int n = 0; n < 400; n++)
      step("rand", rand_instr(), $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
